snn_input_ctrl: RTL and testbench

SNN_INPUT_CTRL -- requirements
Module: snn_input_ctrl

---
 rtl/snn_pkg.sv | 22 ++
 rtl/byte_serializer.sv | 34 +++
 rtl/snn_input_ctrl.sv | 102 ++++++++++
 tb/tb_snn_input_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN input controller: image geometry, FSM states
// and the ASCII encoding used to report the classified digit.
package snn_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int NUM_BYTES  = 98;

  typedef enum logic [2:0] {
    WAIT_BYTE = 3'd0,
    SHIFT     = 3'd1,
    START     = 3'd2,
    RUN       = 3'd3,
    SEND      = 3'd4,
    WAIT_TX   = 3'd5
  } state_t;

  // Digits 0..9 map onto ASCII '0'..'9' by prefixing the high nibble 3.
  function automatic logic [7:0] ascii_digit(input logic [3:0] digit);
    return {4'h3, digit};
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// Turns one received byte into eight pixel bits, LSB first, and flags the
// eighth bit so the controller knows when the byte is exhausted.
module byte_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       shift,
  output logic       bit_out,
  output logic       last
);

  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= data;
      bit_cnt   <= '0;
    end else if (shift) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
      bit_cnt   <= bit_cnt + 3'd1;
    end
  end

  assign bit_out = shift_reg[0];
  assign last    = (bit_cnt == 3'd7);

endmodule

// File: rtl/snn_input_ctrl.sv
// Collects a 784-bit image from UART bytes into the input RAM, launches the
// inference engine and sends the resulting digit back as ASCII.
module snn_input_ctrl #(
  parameter  int NUM_PIXELS = snn_pkg::NUM_PIXELS,
  parameter  int NUM_BYTES  = snn_pkg::NUM_BYTES,
  localparam int ADDR_W     = $clog2(NUM_PIXELS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              clr_rx_rdy,
  output logic              ram_we,
  output logic              ram_d,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [ADDR_W-1:0] eng_addr,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic [3:0]        eng_digit,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy
);

  import snn_pkg::*;

  localparam int                BYTE_W    = $clog2(NUM_BYTES);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

  state_t            state;
  logic [ADDR_W-1:0] pix_addr;
  logic [BYTE_W-1:0] byte_cnt;
  logic [3:0]        digit;
  logic              accept;
  logic              ser_bit;
  logic              ser_last;

  // A pending byte is only taken while idle; elsewhere rx_rdy simply waits.
  assign accept = (state == WAIT_BYTE) && rx_rdy;

  byte_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .data    (rx_data),
    .shift   (state == SHIFT),
    .bit_out (ser_bit),
    .last    (ser_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_BYTE;
      pix_addr <= '0;
      byte_cnt <= '0;
      digit    <= '0;
    end else begin
      case (state)
        WAIT_BYTE: if (rx_rdy) state <= SHIFT;
        SHIFT: begin
          pix_addr <= pix_addr + ADDR_W'(1);
          if (ser_last) begin
            if (byte_cnt == LAST_BYTE) begin
              state <= START;
            end else begin
              byte_cnt <= byte_cnt + BYTE_W'(1);
              state    <= WAIT_BYTE;
            end
          end
        end
        START: state <= RUN;
        RUN: begin
          if (eng_done) begin
            digit <= eng_digit;
            state <= SEND;
          end
        end
        SEND: state <= WAIT_TX;
        WAIT_TX: begin
          if (tx_done) begin
            pix_addr <= '0;
            byte_cnt <= '0;
            state    <= WAIT_BYTE;
          end
        end
        default: state <= WAIT_BYTE;
      endcase
    end
  end

  // The RAM belongs to the engine except while pixels are being written.
  assign ram_we     = (state == SHIFT);
  assign ram_d      = ser_bit;
  assign ram_addr   = ram_we ? pix_addr : eng_addr;
  assign clr_rx_rdy = accept;
  assign eng_start  = (state == START);
  assign tx_start   = (state == SEND);
  assign tx_data    = ascii_digit(digit);
  assign busy       = (state != WAIT_BYTE);

endmodule

// File: tb/tb_snn_input_ctrl.sv
// Scenario-driven bench for snn_input_ctrl with randomized image bytes,
// engine addresses and digits checked against expectations derived here.
module tb_snn_input_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_rx_rdy;
  logic       ram_we;
  logic       ram_d;
  logic [9:0] ram_addr;
  logic [9:0] eng_addr;
  logic       eng_start;
  logic       eng_done;
  logic [3:0] eng_digit;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  localparam int NBYTES = 98;

  snn_input_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .ram_we     (ram_we),
    .ram_d      (ram_d),
    .ram_addr   (ram_addr),
    .eng_addr   (eng_addr),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .eng_digit  (eng_digit),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  // Offers one byte from WAIT_BYTE and checks the handshake plus the eight
  // LSB-first writes at base..base+7. Returns at negedge+1 after the last write.
  task automatic send_byte(input logic [7:0] b, input int base, input string tag);
    logic       exp_d;
    logic [9:0] exp_a;
    @(negedge clk);
    rx_rdy = 1'b1; rx_data = b; eng_done = 1'b0; tx_done = 1'b0;
    eng_addr = 10'($urandom);
    #1;
    checks++; if (clr_rx_rdy !== 1'b1) begin errors++; $display("FAIL %s clr_rx_rdy got %b want 1", tag, clr_rx_rdy); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL %s busy_idle got %b want 0", tag, busy); end
    checks++; if (ram_we !== 1'b0)     begin errors++; $display("FAIL %s ram_we_idle got %b want 0", tag, ram_we); end
    @(negedge clk);
    rx_rdy = 1'b0; rx_data = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      eng_addr = 10'($urandom);
      #1;
      exp_d = ((b >> i) & 8'h01) != 8'h00;
      exp_a = 10'(base + i);
      checks++; if (ram_we !== 1'b1)     begin errors++; $display("FAIL %s ram_we[%0d] got %b want 1", tag, i, ram_we); end
      checks++; if (ram_addr !== exp_a)  begin errors++; $display("FAIL %s ram_addr[%0d] got %0d want %0d", tag, i, ram_addr, exp_a); end
      checks++; if (ram_d !== exp_d)     begin errors++; $display("FAIL %s ram_d[%0d] got %b want %b", tag, i, ram_d, exp_d); end
      checks++; if (clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL %s clr_in_shift[%0d] got %b want 0", tag, i, clr_rx_rdy); end
      @(negedge clk);
    end
    eng_addr = 10'($urandom);
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL %s ram_we_after got %b want 0", tag, ram_we); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; eng_done = 1'b0;
    eng_digit = 4'd0; tx_done = 1'b0; eng_addr = 10'($urandom);
    #5;
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    checks++; if (ram_we !== 1'b0)       begin errors++; $display("FAIL reset ram_we got %b want 0", ram_we); end
    checks++; if (tx_data !== 8'h30)     begin errors++; $display("FAIL reset tx_data got %h want 30", tx_data); end
    checks++; if (eng_start !== 1'b0)    begin errors++; $display("FAIL reset eng_start got %b want 0", eng_start); end
    checks++; if (tx_start !== 1'b0)     begin errors++; $display("FAIL reset tx_start got %b want 0", tx_start); end
    checks++; if (clr_rx_rdy !== 1'b0)   begin errors++; $display("FAIL reset clr_rx_rdy got %b want 0", clr_rx_rdy); end
    checks++; if (ram_addr !== eng_addr) begin errors++; $display("FAIL reset ram_addr got %0d want %0d", ram_addr, eng_addr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_byte();
    send_byte(8'hA5, 0, "single");
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL single busy_after got %b want 0", busy); end
    checks++; if (ram_addr !== eng_addr) begin errors++; $display("FAIL single mux_after got %0d want %0d", ram_addr, eng_addr); end
  endtask

  // Sends bytes first..97 of an image and checks the engine start and RUN entry.
  task automatic test_full_image(input int first);
    logic [7:0] b;
    for (int k = first; k < NBYTES; k++) begin
      b = 8'($urandom);
      send_byte(b, k * 8, "image");
      if (k < NBYTES - 1) begin
        checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL image early_start byte %0d got %b want 0", k, eng_start); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL image busy byte %0d got %b want 0", k, busy); end
      end else begin
        checks++; if (eng_start !== 1'b1)    begin errors++; $display("FAIL image eng_start got %b want 1", eng_start); end
        checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL image busy_start got %b want 1", busy); end
        checks++; if (ram_addr !== eng_addr) begin errors++; $display("FAIL image mux_start got %0d want %0d", ram_addr, eng_addr); end
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      eng_addr = 10'($urandom);
      #1;
      checks++; if (eng_start !== 1'b0)    begin errors++; $display("FAIL run eng_start_repeat got %b want 0", eng_start); end
      checks++; if (ram_addr !== eng_addr) begin errors++; $display("FAIL run mux got %0d want %0d", ram_addr, eng_addr); end
      checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL run busy got %b want 1", busy); end
    end
  endtask

  task automatic test_spurious_tx_done();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tx_done = (c == 0);
      #1;
      checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL spur_tx busy got %b want 1", busy); end
      checks++; if (tx_start !== 1'b0)  begin errors++; $display("FAIL spur_tx tx_start got %b want 0", tx_start); end
      checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL spur_tx eng_start got %b want 0", eng_start); end
    end
  endtask

  task automatic test_spurious_eng_done();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      eng_done = (c == 0); eng_digit = 4'($urandom);
      #1;
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL spur_eng busy got %b want 0", busy); end
      checks++; if (tx_start !== 1'b0)   begin errors++; $display("FAIL spur_eng tx_start got %b want 0", tx_start); end
      checks++; if (eng_start !== 1'b0)  begin errors++; $display("FAIL spur_eng eng_start got %b want 0", eng_start); end
      checks++; if (clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL spur_eng clr got %b want 0", clr_rx_rdy); end
    end
  endtask

  task automatic test_back_pressure_arm(input logic [7:0] b);
    @(negedge clk);
    rx_rdy = 1'b1; rx_data = b;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL bp clr_in_run got %b want 0", clr_rx_rdy); end
      @(negedge clk);
    end
  endtask

  // Completes inference with digit d; leaves tx_done high at negedge+1.
  task automatic test_result(input logic [3:0] d);
    logic [7:0] exp_tx;
    exp_tx = 8'h30 + 8'(d);
    @(negedge clk);
    eng_done = 1'b1; eng_digit = d;
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL result tx_start_early got %b want 0", tx_start); end
    @(negedge clk);
    eng_done = 1'b0; eng_digit = 4'($urandom);
    #1;
    checks++; if (tx_start !== 1'b1)   begin errors++; $display("FAIL result tx_start got %b want 1", tx_start); end
    checks++; if (tx_data !== exp_tx)  begin errors++; $display("FAIL result tx_data got %h want %h", tx_data, exp_tx); end
    checks++; if (clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL result clr got %b want 0", clr_rx_rdy); end
    checks++; if (eng_start !== 1'b0)  begin errors++; $display("FAIL result eng_start got %b want 0", eng_start); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      eng_done = (c == 1); eng_digit = 4'($urandom);
      #1;
      checks++; if (tx_start !== 1'b0)   begin errors++; $display("FAIL wait_tx tx_start got %b want 0", tx_start); end
      checks++; if (tx_data !== exp_tx)  begin errors++; $display("FAIL wait_tx tx_data got %h want %h", tx_data, exp_tx); end
      checks++; if (clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL wait_tx clr got %b want 0", clr_rx_rdy); end
      checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL wait_tx busy got %b want 1", busy); end
    end
    @(negedge clk);
    eng_done = 1'b0; tx_done = 1'b1;
    #1;
    checks++; if (clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL tx_done clr got %b want 0", clr_rx_rdy); end
    checks++; if (tx_data !== exp_tx)  begin errors++; $display("FAIL tx_done tx_data got %h want %h", tx_data, exp_tx); end
  endtask

  task automatic test_back_to_back_image();
    logic [7:0] bp;
    bp = 8'($urandom);
    test_full_image(1);
    test_spurious_tx_done();
    test_back_pressure_arm(bp);
    test_result(4'd7);
    send_byte(bp, 0, "bp_byte");
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp busy_after got %b want 0", busy); end
  endtask

  task automatic test_second_image();
    test_spurious_eng_done();
    test_full_image(1);
    test_result(4'($urandom_range(9)));
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL img2 busy_idle got %b want 0", busy); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL img2 ram_we_idle got %b want 0", ram_we); end
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] b;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) send_byte(8'($urandom), k * 8, "pre_reset");
    @(negedge clk);
    rx_rdy = 1'b1; rx_data = 8'($urandom);
    @(negedge clk);
    rx_rdy = 1'b0;
    #1;
    checks++; if (ram_addr !== 10'd320) begin errors++; $display("FAIL midreset byte40_addr got %0d want 320", ram_addr); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; eng_addr = 10'($urandom);
    #1;
    checks++; if (ram_we !== 1'b0)       begin errors++; $display("FAIL midreset ram_we got %b want 0", ram_we); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL midreset busy got %b want 0", busy); end
    checks++; if (tx_data !== 8'h30)     begin errors++; $display("FAIL midreset tx_data got %h want 30", tx_data); end
    checks++; if (ram_addr !== eng_addr) begin errors++; $display("FAIL midreset mux got %0d want %0d", ram_addr, eng_addr); end
    checks++; if (tx_start !== 1'b0)     begin errors++; $display("FAIL midreset tx_start got %b want 0", tx_start); end
    @(negedge clk);
    rst_n = 1'b1;
    b = 8'($urandom);
    send_byte(b, 0, "post_reset");
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back_image();
    test_second_image();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
